// File: rtl/reaction_game_core.sv
// ---------------------------------------------------------------------------
// reaction_game_core
//   N-player reaction-game engine: ms-tick prescaler, LFSR-randomised pre-go
//   delay, per-player switch synchronisation and edge detection, false-start
//   punishment, first-press arbitration, reaction timing and saturating scores.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   start          raw start button (active high)
//   sw             raw player switches, bit i = player i
//   state          IDLE=0, WAIT=1, GO=2, RESULT=3
//   go             high only in GO
//   winner_valid   round has a winner (held through RESULT)
//   winner_id      winning player index
//   false_start    one-clk pulse per cycle containing false-start presses
//   false_start_id lowest index among that cycle's false starters
//   scores         player i at [i*SCORE_W +: SCORE_W]
//   reaction_ms    ms from GO entry to winning press
//   match_over     some score has reached WIN_SCORE
// ---------------------------------------------------------------------------
module reaction_game_core #(
  parameter int          NUM_PLAYERS      = 2,
  parameter int          TICK_DIV         = 50000,
  parameter int          MIN_DELAY_MS     = 1000,
  parameter int          DELAY_RANGE_BITS = 11,
  parameter int          TIMEOUT_MS       = 5000,
  parameter int          SCORE_W          = 4,
  parameter int          WIN_SCORE        = 9,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  localparam int         ID_W             = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         sw,
  output logic [1:0]                     state,
  output logic                           go,
  output logic                           winner_valid,
  output logic [ID_W-1:0]                winner_id,
  output logic                           false_start,
  output logic [ID_W-1:0]                false_start_id,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [15:0]                    reaction_ms,
  output logic                           match_over
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_GO     = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam int                 DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0]        SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]        TIMEOUT_V = 16'(TIMEOUT_MS);
  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t                  st_q;
  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic [15:0]             lfsr;
  logic [15:0]             delay;
  logic [NUM_PLAYERS-1:0]  dq;

  logic                    start_s1, start_s2, start_prev;
  logic [NUM_PLAYERS-1:0]  sw_s1, sw_s2, sw_prev;
  logic                    start_press;
  logic [NUM_PLAYERS-1:0]  sw_press;

  logic [NUM_PLAYERS-1:0]  live_press;
  logic [ID_W-1:0]         live_id;
  logic [SCORE_W-1:0]      win_cur, win_next;
  logic                    launch;
  logic [15:0]             delay_load;

  assign state = st_q;

  // Lowest set index of a player vector; ties always resolve to player 0 side.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_PLAYERS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  // Free-running ms prescaler.
  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  // Galois LFSR, taps x^16+x^14+x^13+x^11, right-shifting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= SEED;
    else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Two-flop synchronisers plus one history flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
      sw_s1      <= '0;
      sw_s2      <= '0;
      sw_prev    <= '0;
    end else begin
      start_s1   <= start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      sw_s1      <= sw;
      sw_s2      <= sw_s1;
      sw_prev    <= sw_s2;
    end
  end

  assign start_press = start_s2 & ~start_prev;
  assign sw_press    = sw_s2 & ~sw_prev;

  // Presses from players not yet disqualified this round.
  assign live_press = sw_press & ~dq;
  assign live_id    = lowest_idx(live_press);
  assign win_cur    = scores[int'(live_id) * SCORE_W +: SCORE_W];
  assign win_next   = (win_cur == SCORE_MAX) ? win_cur : win_cur + 1'b1;
  assign delay_load = 16'(MIN_DELAY_MS) + 16'(lfsr[DELAY_RANGE_BITS-1:0]);

  // A start press begins a round from IDLE, or from RESULT while the match runs.
  assign launch = start_press && ((st_q == S_IDLE) || ((st_q == S_RESULT) && !match_over));

  // NOTE: scores are ordinary flops rather than a RAM, so they are cleared by
  // reset like every other piece of game state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q           <= S_IDLE;
      go             <= 1'b0;
      winner_valid   <= 1'b0;
      winner_id      <= '0;
      false_start    <= 1'b0;
      false_start_id <= '0;
      scores         <= '0;
      reaction_ms    <= '0;
      match_over     <= 1'b0;
      dq             <= '0;
      delay          <= '0;
    end else begin
      false_start <= 1'b0;
      if (launch) begin
        delay        <= delay_load;
        winner_valid <= 1'b0;
        winner_id    <= '0;
        reaction_ms  <= '0;
        dq           <= '0;
        go           <= 1'b0;
        st_q         <= S_WAIT;
      end else begin
        case (st_q)
          S_WAIT: begin
            if (|live_press) begin
              for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (live_press[i] && (scores[i*SCORE_W +: SCORE_W] != '0))
                  scores[i*SCORE_W +: SCORE_W] <= scores[i*SCORE_W +: SCORE_W] - 1'b1;
              end
              dq             <= dq | live_press;
              false_start    <= 1'b1;
              false_start_id <= live_id;
            end
            // Everyone disqualified: the round ends with no winner.
            if (&(dq | live_press)) begin
              winner_valid <= 1'b0;
              st_q         <= S_RESULT;
            end else if (tick) begin
              delay <= delay - 1'b1;
              if (delay <= 16'd1) begin
                reaction_ms <= '0;
                go          <= 1'b1;
                st_q        <= S_GO;
              end
            end
          end
          S_GO: begin
            // A valid press beats a timeout landing in the same cycle.
            if (|live_press) begin
              scores[int'(live_id) * SCORE_W +: SCORE_W] <= win_next;
              winner_valid <= 1'b1;
              winner_id    <= live_id;
              if (win_next >= WIN_S) match_over <= 1'b1;
              go           <= 1'b0;
              st_q         <= S_RESULT;
            end else if (reaction_ms >= TIMEOUT_V) begin
              winner_valid <= 1'b0;
              go           <= 1'b0;
              st_q         <= S_RESULT;
            end else if (tick && (reaction_ms != 16'hFFFF)) begin
              reaction_ms <= reaction_ms + 1'b1;
            end
          end
          S_RESULT: begin
            // Only reached with match_over set; a plain restart is handled by launch.
            if (start_press) begin
              scores     <= '0;
              match_over <= 1'b0;
              st_q       <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
